// File: rtl/if_stage.sv
// Instruction-fetch stage: one outstanding imem request, a single-entry
// buffer toward decode, and redirect/flush handling from the MEM stage.
module if_stage #(
  parameter logic [31:0] INST_NOP = 32'h00000013
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [63:0] pc_next,
  input  logic        mem_pc_en,
  output logic [63:0] if_pc,
  output logic        imem_req_valid,
  output logic [63:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        imem_resp_err,
  output logic        id_valid,
  output logic [63:0] id_pc,
  output logic [31:0] id_inst,
  output logic [1:0]  id_exc,
  input  logic        id_ready
);

  typedef enum logic [2:0] {
    BOOT  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    DRAIN = 3'd3,
    HOLD  = 3'd4
  } state_e;

  localparam logic [1:0] EXC_NONE  = 2'b00;
  localparam logic [1:0] EXC_ALIGN = 2'b01;
  localparam logic [1:0] EXC_FAULT = 2'b10;

  state_e      state_q;
  logic [63:0] if_pc_q;
  logic [63:0] id_pc_q;
  logic [31:0] id_inst_q;
  logic [1:0]  id_exc_q;
  logic        aligned;
  logic        req_fire;

  assign aligned        = (if_pc_q[1:0] == 2'b00);
  assign imem_req_valid = (state_q == REQ) && aligned;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign if_pc         = if_pc_q;
  assign imem_req_addr = if_pc_q;
  assign id_valid      = (state_q == HOLD);
  assign id_pc         = id_pc_q;
  assign id_inst       = id_inst_q;
  assign id_exc        = id_exc_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= BOOT;
      if_pc_q   <= '0;
      id_pc_q   <= '0;
      id_inst_q <= '0;
      id_exc_q  <= EXC_NONE;
    end else begin
      unique case (state_q)
        BOOT: begin
          if_pc_q <= pc_next;
          state_q <= REQ;
        end
        REQ: begin
          // A redirect wins over the misalignment trap; an accepted request
          // that is redirected in the same cycle must still be drained.
          if (mem_pc_en) begin
            if_pc_q <= pc_next;
            state_q <= req_fire ? DRAIN : REQ;
          end else if (!aligned) begin
            id_pc_q   <= if_pc_q;
            id_inst_q <= INST_NOP;
            id_exc_q  <= EXC_ALIGN;
            state_q   <= HOLD;
          end else if (imem_req_ready) begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (mem_pc_en) begin
            if_pc_q <= pc_next;
            state_q <= imem_resp_valid ? REQ : DRAIN;
          end else if (imem_resp_valid) begin
            id_pc_q   <= if_pc_q;
            id_inst_q <= imem_resp_err ? INST_NOP : imem_resp_data;
            id_exc_q  <= imem_resp_err ? EXC_FAULT : EXC_NONE;
            state_q   <= HOLD;
          end
        end
        DRAIN: begin
          if (mem_pc_en) if_pc_q <= pc_next;
          if (imem_resp_valid) state_q <= REQ;
        end
        HOLD: begin
          if (mem_pc_en || id_ready) begin
            if_pc_q <= pc_next;
            state_q <= REQ;
          end
        end
        default: state_q <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: normal fetch, decode stall, redirect while
// waiting, access fault, flush in HOLD, reset mid-transaction, misaligned PC.
module tb_if_stage;

  logic        clock;
  logic        reset;
  logic [63:0] pc_next;
  logic        mem_pc_en;
  logic [63:0] if_pc;
  logic        imem_req_valid;
  logic [63:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        imem_resp_err;
  logic        id_valid;
  logic [63:0] id_pc;
  logic [31:0] id_inst;
  logic [1:0]  id_exc;
  logic        id_ready;

  logic        use_tgt;
  logic [63:0] tgt;
  int          checks;
  int          errors;

  // Simple PC generator: explicit target when asked, else sequential.
  assign pc_next = use_tgt ? tgt : (if_pc + 64'd4);

  if_stage #(.INST_NOP(32'h00000013)) dut (
    .clock           (clock),
    .reset           (reset),
    .pc_next         (pc_next),
    .mem_pc_en       (mem_pc_en),
    .if_pc           (if_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .imem_resp_err   (imem_resp_err),
    .id_valid        (id_valid),
    .id_pc           (id_pc),
    .id_inst         (id_inst),
    .id_exc          (id_exc),
    .id_ready        (id_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".if_pc"},     if_pc,                  64'd0);
    chk({tag, ".id_valid"},  {63'd0, id_valid},      64'd0);
    chk({tag, ".id_pc"},     id_pc,                  64'd0);
    chk({tag, ".id_inst"},   {32'd0, id_inst},       64'd0);
    chk({tag, ".id_exc"},    {62'd0, id_exc},        64'd0);
    chk({tag, ".req_valid"}, {63'd0, imem_req_valid}, 64'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0;
    mem_pc_en = 1'b0;
    imem_req_ready = 1'b1;
    imem_resp_valid = 1'b0;
    imem_resp_data = '0;
    imem_resp_err = 1'b0;
    id_ready = 1'b1;
    use_tgt = 1'b1;
    tgt = 64'h60000000;

    #2;
    chk_reset("rst");
    step();
    step();
    reset = 1'b1;

    // Normal fetch with immediate ready/response.
    step();
    chk("boot.if_pc", if_pc, 64'h60000000);
    chk("req.valid", {63'd0, imem_req_valid}, 64'd1);
    chk("req.addr", imem_req_addr, 64'h60000000);
    use_tgt = 1'b0;
    step();
    chk("wait.req_valid", {63'd0, imem_req_valid}, 64'd0);
    imem_resp_valid = 1'b1;
    imem_resp_data = 32'h00500093;
    step();
    imem_resp_valid = 1'b0;
    chk("hold.id_valid", {63'd0, id_valid}, 64'd1);
    chk("hold.id_pc", id_pc, 64'h60000000);
    chk("hold.id_inst", {32'd0, id_inst}, 64'h00500093);
    chk("hold.id_exc", {62'd0, id_exc}, 64'd0);
    step();
    chk("next.addr", imem_req_addr, 64'h60000004);
    chk("next.req_valid", {63'd0, imem_req_valid}, 64'd1);
    chk("next.id_valid", {63'd0, id_valid}, 64'd0);

    // Decode stall: held outputs stay stable, no new request.
    id_ready = 1'b0;
    step();
    imem_resp_valid = 1'b1;
    imem_resp_data = 32'h00a00113;
    step();
    imem_resp_valid = 1'b0;
    for (int unsigned i = 0; i < 5; i++) begin
      chk("stall.id_valid", {63'd0, id_valid}, 64'd1);
      chk("stall.id_pc", id_pc, 64'h60000004);
      chk("stall.id_inst", {32'd0, id_inst}, 64'h00a00113);
      chk("stall.req_valid", {63'd0, imem_req_valid}, 64'd0);
      chk("stall.if_pc", if_pc, 64'h60000004);
      step();
    end
    id_ready = 1'b1;
    step();
    chk("unstall.addr", imem_req_addr, 64'h60000008);

    // Redirect while waiting; late response must be discarded.
    step();
    mem_pc_en = 1'b1;
    use_tgt = 1'b1;
    tgt = 64'h60000100;
    step();
    mem_pc_en = 1'b0;
    use_tgt = 1'b0;
    chk("drain.if_pc", if_pc, 64'h60000100);
    chk("drain.req_valid", {63'd0, imem_req_valid}, 64'd0);
    chk("drain.id_valid", {63'd0, id_valid}, 64'd0);
    step();
    chk("drain2.req_valid", {63'd0, imem_req_valid}, 64'd0);
    chk("drain2.id_valid", {63'd0, id_valid}, 64'd0);
    imem_resp_valid = 1'b1;
    imem_resp_data = 32'hdeadbeef;
    step();
    imem_resp_valid = 1'b0;
    chk("redir.req_valid", {63'd0, imem_req_valid}, 64'd1);
    chk("redir.addr", imem_req_addr, 64'h60000100);
    chk("redir.id_valid", {63'd0, id_valid}, 64'd0);

    // Access fault.
    id_ready = 1'b0;
    step();
    imem_resp_valid = 1'b1;
    imem_resp_err = 1'b1;
    imem_resp_data = 32'hcafef00d;
    step();
    imem_resp_valid = 1'b0;
    imem_resp_err = 1'b0;
    chk("fault.id_valid", {63'd0, id_valid}, 64'd1);
    chk("fault.id_exc", {62'd0, id_exc}, 64'd2);
    chk("fault.id_inst", {32'd0, id_inst}, 64'h00000013);
    chk("fault.id_pc", id_pc, 64'h60000100);

    // Flush in HOLD with id_ready also high.
    id_ready = 1'b1;
    mem_pc_en = 1'b1;
    use_tgt = 1'b1;
    tgt = 64'h60000200;
    step();
    mem_pc_en = 1'b0;
    use_tgt = 1'b0;
    chk("flush.id_valid", {63'd0, id_valid}, 64'd0);
    chk("flush.addr", imem_req_addr, 64'h60000200);

    // Reset asserted in WAIT takes effect without a clock edge.
    step();
    chk("wait2.req_valid", {63'd0, imem_req_valid}, 64'd0);
    #2;
    reset = 1'b0;
    #1;
    chk_reset("async_rst");

    // Misaligned boot PC, with a stale response around reset release.
    use_tgt = 1'b1;
    tgt = 64'h60000002;
    imem_resp_valid = 1'b1;
    imem_resp_data = 32'h11111111;
    step();
    reset = 1'b1;
    step();
    imem_resp_valid = 1'b0;
    chk("mis.if_pc", if_pc, 64'h60000002);
    chk("mis.req_valid", {63'd0, imem_req_valid}, 64'd0);
    chk("mis.id_valid0", {63'd0, id_valid}, 64'd0);
    use_tgt = 1'b0;
    id_ready = 1'b0;
    step();
    chk("mis.id_valid", {63'd0, id_valid}, 64'd1);
    chk("mis.id_exc", {62'd0, id_exc}, 64'd1);
    chk("mis.id_inst", {32'd0, id_inst}, 64'h00000013);
    chk("mis.id_pc", id_pc, 64'h60000002);
    chk("mis.hold_req", {63'd0, imem_req_valid}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter INST_NOP, default 32'h00000013, SHALL be the word driven on id_inst for faulted fetches.
REQ-002 clock  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; assertion SHALL force reset state immediately, independent of clock.
REQ-004 pc_next  input  64  next fetch PC from the PC-generation stage (redirect target when mem_pc_en=1, else if_pc+4).
REQ-005 mem_pc_en  input  1  redirect/flush pulse from MEM stage.
REQ-006 if_pc  output  64  registered current fetch PC, fed back to PC generation.
REQ-007 imem_req_valid  output  1  instruction-memory request valid.
REQ-008 imem_req_addr  output  64  request address; SHALL equal if_pc.
REQ-009 imem_req_ready  input  1  request accepted when high with imem_req_valid.
REQ-010 imem_resp_valid  input  1  one-cycle response strobe.
REQ-011 imem_resp_data  input  32  fetched instruction word.
REQ-012 imem_resp_err  input  1  access fault, qualified by imem_resp_valid.
REQ-013 id_valid  output  1  instruction valid to decode.
REQ-014 id_pc  output  64  PC of held instruction.
REQ-015 id_inst  output  32  held instruction.
REQ-016 id_exc  output  2  00 none, 01 misaligned, 10 access fault.
REQ-017 id_ready  input  1  decode accepts when high with id_valid.

Function
REQ-018 States SHALL be BOOT, REQ, WAIT, DRAIN, HOLD; at most one imem request outstanding.
REQ-019 BOOT: if_pc <= pc_next; -> REQ (one cycle, unconditional).
REQ-020 REQ, if_pc[1:0]==0: imem_req_valid=1 (combinational from state); on imem_req_ready -> WAIT.
REQ-021 REQ, if_pc[1:0]!=0: imem_req_valid=0; -> HOLD with id_exc=01, id_inst=INST_NOP, id_pc=if_pc.
REQ-022 WAIT, imem_resp_valid: -> HOLD, id_inst=imem_resp_data, id_pc=if_pc, id_exc=00; if imem_resp_err, id_exc=10 and id_inst=INST_NOP.
REQ-023 HOLD: id_valid=1; on id_ready, if_pc <= pc_next, -> REQ, id_valid=0 next cycle.
REQ-024 if_pc SHALL change only per REQ-019, REQ-023, REQ-025..REQ-028; imem_req_addr may change only while not accepted.
REQ-025 mem_pc_en in REQ: if_pc <= pc_next; if handshake same cycle -> DRAIN, else stay REQ.
REQ-026 mem_pc_en in WAIT: if_pc <= pc_next; with imem_resp_valid same cycle response discarded -> REQ; otherwise -> DRAIN.
REQ-027 DRAIN: imem_req_valid=0; on imem_resp_valid discard response -> REQ; mem_pc_en in DRAIN updates if_pc, stays DRAIN unless response arrives.
REQ-028 mem_pc_en in HOLD: buffered instruction dropped, id_valid=0 next cycle, if_pc <= pc_next, -> REQ, even if id_ready high same cycle.
REQ-029 mem_pc_en in BOOT SHALL have no extra effect beyond REQ-019.
REQ-030 Min latency pc load to id_valid: 3 cycles (REQ with ready, WAIT with resp, HOLD).

Reset
REQ-031 Reset state: BOOT, if_pc=0, id_valid=0, id_pc=0, id_inst=0, id_exc=00, imem_req_valid=0.
REQ-032 Reset mid-transaction SHALL abandon any outstanding request; a late response after reset release SHALL be ignored outside WAIT/DRAIN.

Verification
REQ-033 Release reset, pc_next=0x60000000, ready/resp immediate, data 0x00500093, id_ready=1 -> id_valid with id_pc=0x60000000, id_inst=0x00500093, then next request addr 0x60000004.
REQ-034 HOLD with id_ready=0 for 5 cycles -> id_valid, id_pc, id_inst stable, no new request, if_pc unchanged.
REQ-035 mem_pc_en in WAIT with pc_next=0x60000100, response 2 cycles later -> response discarded, next request addr 0x60000100, no id_valid for old PC.
REQ-036 pc_next=0x60000002 at BOOT -> no imem request, id_valid=1, id_exc=01, id_inst=0x00000013.
REQ-037 Response with imem_resp_err=1 -> id_exc=10, id_inst=0x00000013, id_pc=request PC.
REQ-038 Assert reset in WAIT -> all outputs at reset values immediately, without clock edge.
